// File: rtl/aes_req_arb.sv
// aes_req_arb: round-robin front end that shares one fixed-latency aes_128
// core between two requesters (A and B).
//
// Each requester offers {pt, key} with a valid/ready handshake. At most one
// request is accepted per cycle. The winner's operands are registered onto
// core_state/core_key. A tracker pipeline follows each request through the
// core so that its ciphertext can be tagged with the owner's id. Each
// requester is limited to MAXOUT requests in flight by a credit counter.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   a_valid/a_ready        requester A handshake (ready is combinational)
//   a_pt, a_key            requester A plaintext and key
//   b_valid/b_ready        requester B handshake
//   b_pt, b_key            requester B plaintext and key
//   core_state, core_key   registered operands driven to aes_128
//   core_out               aes_128 ciphertext, LAT cycles after its operands
//   rsp_valid              one-cycle pulse per completed request
//   rsp_id, rsp_data       owner (0=A, 1=B) and ciphertext, held between pulses
//   busy                   at least one request is in flight or responding
module aes_req_arb #(
  parameter int LAT    = 21,
  parameter int MAXOUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [127:0] a_pt,
  input  logic [127:0] a_key,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [127:0] b_pt,
  input  logic [127:0] b_key,
  output logic [127:0] core_state,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         busy
);

  localparam logic [2:0] MAX_CNT = 3'(MAXOUT);

  logic [2:0] a_cnt, b_cnt;
  logic       last_a;            // 1 when the most recent grant went to A
  logic       a_elig, b_elig;
  logic       xfer, win_id;
  logic       a_dec, b_dec;

  // Stage k holds a request whose operands were loaded k cycles ago; stage
  // LAT is therefore the cycle in which core_out carries its ciphertext.
  logic [LAT:0] trk_v;
  logic [LAT:0] trk_id;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here: unconditional assignments), so no latch can be inferred.
  always_comb begin
    a_elig  = a_valid && (a_cnt < MAX_CNT);
    b_elig  = b_valid && (b_cnt < MAX_CNT);
    // Tie goes to whoever was not granted last; readies are forced low
    // while reset is asserted.
    a_ready = rst_n && a_elig && (!b_elig || !last_a);
    b_ready = rst_n && b_elig && (!a_elig || last_a);
    xfer    = a_ready || b_ready;
    win_id  = b_ready;
  end

  // Credits return on the response pulse, so a credit freed by a response
  // becomes usable only in the following cycle.
  assign a_dec = rsp_valid && !rsp_id;
  assign b_dec = rsp_valid &&  rsp_id;

  assign busy = (|trk_v) || rsp_valid;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_a <= 1'b0;
    end else if (xfer) begin
      last_a <= a_ready;
    end
  end

  // NOTE: the wide operand/result registers are reset too, so the core and
  // downstream logic never see leftover data from before a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_state <= '0;
      core_key   <= '0;
    end else if (xfer) begin
      core_state <= b_ready ? b_pt  : a_pt;
      core_key   <= b_ready ? b_key : a_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_v  <= '0;
      trk_id <= '0;
    end else begin
      trk_v  <= {trk_v[LAT-1:0], xfer};
      trk_id <= {trk_id[LAT-1:0], win_id};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= trk_v[LAT];
      if (trk_v[LAT]) begin
        rsp_id   <= trk_id[LAT];
        rsp_data <= core_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_ready && !a_dec) begin
        a_cnt <= a_cnt + 3'd1;
      end else if (!a_ready && a_dec && (a_cnt != 3'd0)) begin
        a_cnt <= a_cnt - 3'd1;
      end
      if (b_ready && !b_dec) begin
        b_cnt <= b_cnt + 3'd1;
      end else if (!b_ready && b_dec && (b_cnt != 3'd0)) begin
        b_cnt <= b_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_req_arb.sv
// Testbench for aes_req_arb. A behavioural stand-in for aes_128 (a LAT-deep
// pipeline of a simple keyed function, returning the known AES(0,0) value
// for all-zero operands) feeds core_out. A scoreboard of expected responses
// (owner, data, arrival cycle) is built from the expected grants, and every
// cycle the bench checks readies, operand registers, busy and the response
// outputs against it.
module tb_aes_req_arb;

  localparam int LAT    = 21;
  localparam int MAXOUT = 4;
  // Accepted in cycle c (edge E ends it): the pulse appears after edge
  // E+LAT+1, which is cycle c+LAT+2 in the bench's cycle numbering.
  localparam int RSP_DLY = LAT + 2;
  localparam logic [127:0] AES_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KB = 128'hf0e0d0c0b0a090807060504030201000;

  logic         clk, rst_n;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [127:0] a_pt, a_key, b_pt, b_key;
  logic [127:0] core_state, core_key, core_out;
  logic         rsp_valid, rsp_id, busy;
  logic [127:0] rsp_data;

  aes_req_arb #(.LAT(LAT), .MAXOUT(MAXOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_pt       (a_pt),
    .a_key      (a_key),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_pt       (b_pt),
    .b_key      (b_key),
    .core_state (core_state),
    .core_key   (core_key),
    .core_out   (core_out),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] fake_aes(input logic [127:0] s, input logic [127:0] k);
    if (s == '0 && k == '0) return AES_ZERO;
    return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_96969696_0f0f0f0f;
  endfunction

  // Stand-in for aes_128: fixed LAT-cycle latency from core_state/core_key.
  logic [127:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fake_aes(core_state, core_key);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_out = pipe[LAT-1];

  typedef struct {
    logic         id;
    logic [127:0] data;
    int           cyc;
  } rsp_t;
  rsp_t exp_q[$];

  typedef struct {
    logic         av, bv;
    logic [127:0] apt, bpt;
    logic         ea, eb;
  } vec_t;
  vec_t vecs [14];

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc   = 0;
  logic [127:0] m_state = '0, m_key = '0, m_rsp_data = '0;
  logic         m_rsp_id = 1'b0;

  function automatic logic [127:0] pa(input int i);
    return {32'ha0a0a0a0, 64'h1111_2222_3333_4444, 32'(i)};
  endfunction

  function automatic logic [127:0] pb(input int i);
    return {32'hb0b0b0b0, 64'h5555_6666_7777_8888, 32'(i)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the
  // falling edge, record expected grants, then advance to the next edge.
  task automatic cycle(input logic av, input logic bv,
                       input logic [127:0] apt, input logic [127:0] akey,
                       input logic [127:0] bpt, input logic [127:0] bkey,
                       input logic ea, input logic eb);
    a_valid = av; a_pt = apt; a_key = akey;
    b_valid = bv; b_pt = bpt; b_key = bkey;
    @(negedge clk);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    check("core_state", core_state, m_state);
    check("core_key", core_key, m_key);
    check("busy", busy, exp_q.size() != 0);
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_id", rsp_id, exp_q[0].id);
      check("rsp_data", rsp_data, exp_q[0].data);
      m_rsp_id   = exp_q[0].id;
      m_rsp_data = exp_q[0].data;
      void'(exp_q.pop_front());
    end else begin
      check("rsp_valid_idle", rsp_valid, 1'b0);
      check("rsp_id_hold", rsp_id, m_rsp_id);
      check("rsp_data_hold", rsp_data, m_rsp_data);
    end
    if (ea) begin
      exp_q.push_back('{id: 1'b0, data: fake_aes(apt, akey), cyc: cyc + RSP_DLY});
      m_state = apt; m_key = akey;
    end else if (eb) begin
      exp_q.push_back('{id: 1'b1, data: fake_aes(bpt, bkey), cyc: cyc + RSP_DLY});
      m_state = bpt; m_key = bkey;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 80) begin
      idle(1);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 128'(exp_q.size()), '0);
      exp_q.delete();
    end
    idle(2);
  endtask

  // Assert reset (called just after a rising edge) with both requesters
  // pushing, check the cleared state, then release just after an edge.
  task automatic do_reset(input int n);
    a_valid = 1'b1; b_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_core_state", core_state, '0);
    check("rst_core_key", core_key, '0);
    exp_q.delete();
    m_state = '0; m_key = '0; m_rsp_data = '0; m_rsp_id = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_hold_a_ready", a_ready, 1'b0);
    check("rst_hold_busy", busy, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Grants from a fresh reset: ties alternate starting with A; both
    // requesters reach MAXOUT after four grants each.
    vecs[0]  = '{1'b1, 1'b1, pa(0),  pb(0),  1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, pa(1),  pb(1),  1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, pa(2),  pb(2),  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, pa(3),  pb(3),  1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, pa(4),  pb(4),  1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, pa(5),  pb(5),  1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, pa(6),  pb(6),  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, pa(7),  pb(7),  1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, pa(8),  pb(8),  1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, pa(9),  pb(9),  1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, pa(10), pb(10), 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, pa(11), pb(11), 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, pa(12), pb(12), 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, pa(13), pb(13), 1'b0, 1'b0};

    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_pt = '0; a_key = '0; b_pt = '0; b_key = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Single all-zero request straight after reset.
    cycle(1'b1, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    drain();

    // Table of arbitration vectors from a fresh reset.
    do_reset(2);
    for (int i = 0; i < 14; i++)
      cycle(vecs[i].av, vecs[i].bv, vecs[i].apt, KA, vecs[i].bpt, KB, vecs[i].ea, vecs[i].eb);
    drain();

    // A alone and continuous: four accepts, stall until the first response,
    // then one accept per returning credit.
    for (int k = 0; k < 30; k++)
      cycle(1'b1, 1'b0, pa(100 + k), KA, '0, '0, (k < 4) || (k >= 24 && k <= 27), 1'b0);
    drain();

    // A saturates, B fills its own credits, then each resumes as its
    // credits come back.
    for (int k = 0; k < 33; k++)
      cycle(1'b1, k >= 4, pa(200 + k), KA, pb(200 + k), KB,
            (k < 4) || (k >= 24 && k <= 27),
            (k >= 4 && k <= 7) || (k >= 28 && k <= 31));
    drain();

    // Reset with three requests in flight: nothing may come back for them.
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 1'b0, pa(300 + k), KA, '0, '0, 1'b1, 1'b0);
    idle(10);
    do_reset(2);
    idle(30);
    // Credits must be fully restored: four accepts, then a stall.
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b0, pa(400 + k), KA, '0, '0, k < 4, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
